// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Purpose  : Shared definitions for the sorted schedule table and its
//             binary-search position finder.
//  Revision : 1.0 - initial release
// ============================================================================
package sched_pkg;

    localparam int DEPTH  = 16;
    localparam int INFO_W = 32;
    localparam int IDX_W  = 4;

    // Unused slots hold the largest key so the table remains sorted
    localparam logic [INFO_W-1:0] EMPTY_KEY = {INFO_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } ins_state_t;

    // Per-slot next-value source
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_PREV = 2'd1,
        SEL_NEXT = 2'd2,
        SEL_INS  = 2'd3
    } slot_sel_t;

    // Table image shared with the searcher, slot 0 = smallest key
    typedef logic [DEPTH-1:0][INFO_W-1:0] sched_table_t;

endpackage : sched_pkg
`default_nettype wire

// File: rtl/sched_insert.sv
`default_nettype none
// ============================================================================
//  Module   : sched_insert
//  Purpose  : Sorted task table. Inserts a key at a searcher-supplied slot by
//             rippling the tail down one slot per cycle, and pops the head
//             record in a single cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sched_insert #(
    parameter int DEPTH  = 16,
    parameter int INFO_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ins_valid,
    output logic                           ins_ready,
    input  logic [IDX_W-1:0]               ins_pos,
    input  logic [INFO_W-1:0]              ins_info,
    input  logic                           pop_req,
    output logic                           pop_valid,
    output logic [INFO_W-1:0]              pop_info,
    output logic [DEPTH-1:0][INFO_W-1:0]   schden_info,
    output logic [IDX_W:0]                 count,
    output logic                           full,
    output logic                           empty,
    output logic                           busy
);

    import sched_pkg::*;

    // Counters and indices carry one extra bit so DEPTH itself is representable
    localparam int                  c_cnt_w     = IDX_W + 1;
    localparam logic [INFO_W-1:0]   c_empty_key = {INFO_W{1'b1}};
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_one       = c_cnt_w'(1);

    ins_state_t                     r_state;
    ins_state_t                     w_state_nxt;
    logic [DEPTH-1:0][INFO_W-1:0]   r_table;
    logic [c_cnt_w-1:0]             r_count;
    logic [c_cnt_w-1:0]             r_idx;
    logic [c_cnt_w-1:0]             r_pos;
    logic [INFO_W-1:0]              r_info;
    logic [INFO_W-1:0]              r_pop_info;
    logic                           r_pop_valid;

    logic [c_cnt_w-1:0]             w_ins_pos_ext;
    logic [c_cnt_w-1:0]             w_pos_clamp;
    logic [c_cnt_w-1:0]             w_idx_dec;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_do_pop;
    logic                           w_do_accept;
    logic                           w_ins_ready;
    slot_sel_t                      w_sel [DEPTH];
    logic [DEPTH-1:0][INFO_W-1:0]   w_prev;
    logic [DEPTH-1:0][INFO_W-1:0]   w_next;

    assign w_full        = (r_count == c_depth);
    assign w_empty       = (r_count == '0);
    // Pop wins over insert in IDLE; an insert is never accepted alongside pop_req
    assign w_do_pop      = (r_state == IDLE) && pop_req && !w_empty;
    assign w_ins_ready   = (r_state == IDLE) && !w_full && !pop_req && !rst;
    assign w_do_accept   = ins_valid && w_ins_ready;
    // A position past the occupied region degenerates to an append
    assign w_ins_pos_ext = {1'b0, ins_pos};
    assign w_pos_clamp   = (w_ins_pos_ext < r_count) ? w_ins_pos_ext : r_count;
    assign w_idx_dec     = r_idx - c_one;

    // Neighbour taps for shifting; edge slots see the empty key
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_prev_edge
            assign w_prev[i] = c_empty_key;
        end else begin : g_prev_tap
            assign w_prev[i] = r_table[i-1];
        end
        if (i == DEPTH - 1) begin : g_next_edge
            assign w_next[i] = c_empty_key;
        end else begin : g_next_tap
            assign w_next[i] = r_table[i+1];
        end
    end

    // Insert FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_do_accept) begin
                    w_state_nxt = (r_count > w_pos_clamp) ? SHIFT : WRITE;
                end
            end
            SHIFT: begin
                if (w_idx_dec == r_pos) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-slot source select: pop shifts everything up, SHIFT moves one slot down, WRITE lands the key
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = SEL_HOLD;
            if (w_do_pop) begin
                w_sel[i] = SEL_NEXT;
            end else if ((r_state == SHIFT) && (r_idx == c_cnt_w'(i))) begin
                w_sel[i] = SEL_PREV;
            end else if ((r_state == WRITE) && (r_pos == c_cnt_w'(i))) begin
                w_sel[i] = SEL_INS;
            end
        end
    end

    // FSM state, occupancy, insert bookkeeping and pop result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_pos       <= '0;
            r_info      <= '0;
            r_pop_valid <= 1'b0;
            r_pop_info  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pop_valid <= w_do_pop;
            if (w_do_pop) begin
                r_pop_info <= r_table[0];
                r_count    <= r_count - c_one;
            end
            if (w_do_accept) begin
                r_pos  <= w_pos_clamp;
                r_idx  <= r_count;
                r_info <= ins_info;
            end
            if (r_state == SHIFT) begin
                r_idx <= w_idx_dec;
            end
            if (r_state == WRITE) begin
                r_count <= r_count + c_one;
            end
        end
    end

    // Table storage driven by the per-slot select
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_table[i] <= c_empty_key;
            end else begin
                case (w_sel[i])
                    SEL_PREV: r_table[i] <= w_prev[i];
                    SEL_NEXT: r_table[i] <= w_next[i];
                    SEL_INS:  r_table[i] <= r_info;
                    default:  r_table[i] <= r_table[i];
                endcase
            end
        end
    end

    assign ins_ready   = w_ins_ready;
    assign pop_valid   = r_pop_valid;
    assign pop_info    = r_pop_info;
    assign schden_info = r_table;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign busy        = (r_state != IDLE);

endmodule : sched_insert
`default_nettype wire

// File: tb/tb_sched_insert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sched_insert
//  Purpose  : Directed self-checking bench for sched_insert.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sched_insert;

    localparam int            c_depth = 16;
    localparam logic [31:0]   c_empty = 32'hFFFF_FFFF;

    logic                         clk;
    logic                         rst;
    logic                         ins_valid;
    logic                         ins_ready;
    logic [3:0]                   ins_pos;
    logic [31:0]                  ins_info;
    logic                         pop_req;
    logic                         pop_valid;
    logic [31:0]                  pop_info;
    logic [c_depth-1:0][31:0]     schden_info;
    logic [4:0]                   count;
    logic                         full;
    logic                         empty;
    logic                         busy;

    int n_chk;
    int n_err;
    int lat;

    sched_insert #(
        .DEPTH  (16),
        .INFO_W (32),
        .IDX_W  (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_pos     (ins_pos),
        .ins_info    (ins_info),
        .pop_req     (pop_req),
        .pop_valid   (pop_valid),
        .pop_info    (pop_info),
        .schden_info (schden_info),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        ins_valid = 1'b0;
        pop_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one insert, wait for acceptance, return edges from accept until idle
    task automatic do_ins(input logic [3:0] pos, input logic [31:0] info, output int l);
        int waited;
        @(negedge clk);
        ins_valid = 1'b1;
        ins_pos   = pos;
        ins_info  = info;
        #1;
        waited = 0;
        while (!ins_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ins_ready) begin
            check("ins_ready_timeout", 32'(ins_ready), 32'd1);
            ins_valid = 1'b0;
            l = -1;
            return;
        end
        @(negedge clk);
        ins_valid = 1'b0;
        l = 1;
        while (busy && l < 60) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        ins_valid = 1'b0;
        ins_pos   = '0;
        ins_info  = '0;
        pop_req   = 1'b0;

        // ---------------- reset values and first insert ----------------
        @(negedge clk);
        ins_valid = 1'b1;
        #1;
        check("ready_in_rst", 32'(ins_ready), 32'd0);
        ins_valid = 1'b0;
        do_reset();
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_pop_info", pop_info, 32'd0);
        check("rst_slot0", schden_info[0], c_empty);

        @(negedge clk);
        ins_valid = 1'b1;
        ins_pos   = 4'd0;
        ins_info  = 32'h10;
        @(negedge clk);
        ins_valid = 1'b0;
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        check("t1_count_before_write", 32'(count), 32'd0);
        @(negedge clk);
        check("t1_slot0", schden_info[0], 32'h10);
        check("t1_count", 32'(count), 32'd1);
        check("t1_slot1", schden_info[1], c_empty);
        check("t1_slot15", schden_info[15], c_empty);
        check("t1_busy_done", 32'(busy), 32'd0);

        // ---------------- mid-table insert with two shifts ----------------
        do_ins(4'd1, 32'h30, lat);
        check("t2_append_lat", 32'(lat), 32'd2);
        do_ins(4'd2, 32'h50, lat);
        do_ins(4'd1, 32'h20, lat);
        check("t2_shift_lat", 32'(lat), 32'd4);
        check("t2_slot0", schden_info[0], 32'h10);
        check("t2_slot1", schden_info[1], 32'h20);
        check("t2_slot2", schden_info[2], 32'h30);
        check("t2_slot3", schden_info[3], 32'h50);
        check("t2_slot4", schden_info[4], c_empty);
        check("t2_count", 32'(count), 32'd4);

        // ---------------- clamped position ----------------
        do_reset();
        do_ins(4'd0, 32'h10, lat);
        do_ins(4'd1, 32'h30, lat);
        do_ins(4'd2, 32'h50, lat);
        do_ins(4'd9, 32'h99, lat);
        check("t5_lat", 32'(lat), 32'd2);
        check("t5_slot3", schden_info[3], 32'h99);
        check("t5_slot2", schden_info[2], 32'h50);
        check("t5_slot4", schden_info[4], c_empty);
        check("t5_count", 32'(count), 32'd4);

        // ---------------- simultaneous pop and insert ----------------
        do_reset();
        do_ins(4'd0, 32'h10, lat);
        do_ins(4'd1, 32'h20, lat);
        @(negedge clk);
        ins_valid = 1'b1;
        ins_pos   = 4'd2;
        ins_info  = 32'h40;
        pop_req   = 1'b1;
        #1;
        check("t4_ready_with_pop", 32'(ins_ready), 32'd0);
        @(negedge clk);
        pop_req = 1'b0;
        #1;
        check("t4_pop_valid", 32'(pop_valid), 32'd1);
        check("t4_pop_info", pop_info, 32'h10);
        check("t4_count_after_pop", 32'(count), 32'd1);
        check("t4_slot0_after_pop", schden_info[0], 32'h20);
        check("t4_busy_stalled", 32'(busy), 32'd0);
        check("t4_ready_next", 32'(ins_ready), 32'd1);
        @(negedge clk);
        ins_valid = 1'b0;
        check("t4_busy_accepted", 32'(busy), 32'd1);
        check("t4_pop_valid_pulse", 32'(pop_valid), 32'd0);
        @(negedge clk);
        check("t4_slot1", schden_info[1], 32'h40);
        check("t4_count", 32'(count), 32'd2);

        // ---------------- pop while empty ----------------
        do_reset();
        @(negedge clk);
        pop_req = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
        check("t6_empty_pop_valid", 32'(pop_valid), 32'd0);
        check("t6_empty_pop_count", 32'(count), 32'd0);

        // ---------------- full table ----------------
        for (int k = 0; k < 16; k++) begin
            do_ins(4'(k), 32'((k + 1) * 16), lat);
        end
        check("t3_full", 32'(full), 32'd1);
        check("t3_count16", 32'(count), 32'd16);
        @(negedge clk);
        ins_valid = 1'b1;
        ins_pos   = 4'd0;
        ins_info  = 32'h5;
        repeat (3) @(negedge clk);
        check("t3_ready_full", 32'(ins_ready), 32'd0);
        check("t3_busy_full", 32'(busy), 32'd0);
        check("t3_slot0_kept", schden_info[0], 32'h10);
        pop_req = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
        #1;
        check("t3_pop_valid", 32'(pop_valid), 32'd1);
        check("t3_pop_info", pop_info, 32'h10);
        check("t3_count15", 32'(count), 32'd15);
        check("t3_slot15_empty", schden_info[15], c_empty);
        check("t3_ready_after_pop", 32'(ins_ready), 32'd1);
        @(negedge clk);
        ins_valid = 1'b0;
        check("t3_pop_valid_pulse", 32'(pop_valid), 32'd0);
        lat = 1;
        while (busy && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("t3_lat", 32'(lat), 32'd17);
        check("t3_slot0", schden_info[0], 32'h5);
        check("t3_slot1", schden_info[1], 32'h20);
        check("t3_slot15", schden_info[15], 32'h100);
        check("t3_count_refull", 32'(count), 32'd16);

        // ---------------- reset during shift ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_ins(4'(k), 32'((k + 1) * 32'h100), lat);
        end
        @(negedge clk);
        ins_valid = 1'b1;
        ins_pos   = 4'd0;
        ins_info  = 32'h1;
        @(negedge clk);
        ins_valid = 1'b0;
        @(negedge clk);
        check("t7_busy_mid_shift", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_ready_in_rst", 32'(ins_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t7_count", 32'(count), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_empty", 32'(empty), 32'd1);
        check("t7_pop_valid", 32'(pop_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t7_slot%0d", k), schden_info[k], c_empty);
        end
        repeat (3) @(negedge clk);
        check("t7_stay_idle", 32'(busy), 32'd0);
        check("t7_stay_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sched_insert
`default_nettype wire
